// File: rtl/output_control_pkg.sv
// output_control_pkg
// Shared types and constants for the result-side output stage:
//   out_state_t    - control FSM states (IDLE, CONVERT, SHOW)
//   OP_DIV/OP_SQRT - opcodes for which a remainder/residual is meaningful
//   BCD_ERR_NIBBLE - nibble value shown on every digit when an error is displayed
//   dabble_adjust  - add-3 correction applied to one BCD digit before each shift
package output_control_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CONVERT = 2'b01,
        SHOW    = 2'b10
    } out_state_t;

    localparam logic [1:0] OP_DIV         = 2'b00;
    localparam logic [1:0] OP_SQRT        = 2'b01;
    localparam logic [3:0] BCD_ERR_NIBBLE = 4'hF;

    // Double-dabble correction: a digit of 5 or more would overflow past 9
    // after the next doubling, so bias it by 3 first.
    function automatic logic [3:0] dabble_adjust(input logic [3:0] digit);
        if (digit >= 4'd5) begin
            return digit + 4'd3;
        end else begin
            return digit;
        end
    endfunction

endpackage

// File: rtl/output_control_if.sv
// output_control_if
// Bundles the core-result inputs, the raw operator buttons and the display
// outputs of output_control.
//   slave  - used by output_control: core/button signals in, display signals out
//   master - used by whoever drives the core side and observes the display
interface output_control_if #(
    parameter int WORD_LENGHT = 8,
    parameter int BCD_DIGITS  = 3
);

    logic [WORD_LENGHT-1:0]  result;
    logic                    result_sign;
    logic [WORD_LENGHT-1:0]  remainder;
    logic [1:0]              opCode;
    logic                    done;
    logic                    error_in;
    logic                    start;
    logic                    load;

    logic [WORD_LENGHT:0]    data_out;
    logic                    sign_out;
    logic [4*BCD_DIGITS-1:0] bcd_out;
    logic                    valid_out;
    logic                    busy;
    logic                    showing_remainder;
    logic                    error_out;

    modport slave (
        input  result, result_sign, remainder, opCode, done, error_in, start, load,
        output data_out, sign_out, bcd_out, valid_out, busy, showing_remainder, error_out
    );

    modport master (
        output result, result_sign, remainder, opCode, done, error_in, start, load,
        input  data_out, sign_out, bcd_out, valid_out, busy, showing_remainder, error_out
    );

endinterface

// File: rtl/ONEshot.sv
// ONEshot
// Turns a raw button level into a single-cycle registered pulse on its rising edge.
//   clk       - system clock
//   rst       - asynchronous active-low reset (clears the edge history)
//   sig_in    - raw level
//   pulse_out - one-cycle pulse, one cycle after sig_in rises
module ONEshot (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic pulse_out
);

    logic prev_r;
    logic pulse_r;

    // Edge history and registered rising-edge pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            prev_r  <= sig_in;
            pulse_r <= sig_in & ~prev_r;
        end
    end

    assign pulse_out = pulse_r;

endmodule

// File: rtl/output_control_bcd.sv
// bin_to_bcd_seq
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
//   clk, rst - clock and asynchronous active-low reset
//   start    - load bin_in and (re)start; accepted even while busy
//   bin_in   - unsigned binary value to convert
//   busy     - iterations in progress
//   done     - one-cycle pulse once bcd_out holds the new result
//   bcd_out  - packed BCD result, digit 0 in the LSBs; held until the next run
module bin_to_bcd_seq
    import output_control_pkg::*;
#(
    parameter int WORD_LENGHT = 8,
    parameter int BCD_DIGITS  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WORD_LENGHT-1:0]  bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd_out
);

    localparam int CW = $clog2(WORD_LENGHT + 1);

    logic [WORD_LENGHT-1:0]  bin_r;
    logic [4*BCD_DIGITS-1:0] bcd_r;
    logic [4*BCD_DIGITS-1:0] bcd_out_r;
    logic [CW-1:0]           cnt_r;
    logic                    busy_r;
    logic                    done_r;
    logic [4*BCD_DIGITS-1:0] adj_s;
    logic [4*BCD_DIGITS-1:0] bcd_next_s;

    // Add-3 correction on every digit, then shift the next binary MSB in.
    always_comb begin
        adj_s = bcd_r;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            adj_s[4*i +: 4] = dabble_adjust(bcd_r[4*i +: 4]);
        end
        bcd_next_s = {adj_s[4*BCD_DIGITS-2:0], bin_r[WORD_LENGHT-1]};
    end

    // Iteration counter, shift registers and result latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_r     <= '0;
            bcd_r     <= '0;
            bcd_out_r <= '0;
            cnt_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else if (start) begin
            bin_r  <= bin_in;
            bcd_r  <= '0;
            cnt_r  <= CW'(WORD_LENGHT);
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            bcd_r <= bcd_next_s;
            bin_r <= {bin_r[WORD_LENGHT-2:0], 1'b0};
            cnt_r <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
                busy_r    <= 1'b0;
                done_r    <= 1'b1;
                bcd_out_r <= bcd_next_s;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign bcd_out = bcd_out_r;

endmodule

// File: rtl/output_control.sv
// output_control
// Captures the sign-magnitude result/remainder/error from the arithmetic core on
// `done`, converts the selected value to two's complement and BCD, and holds it
// for the display. `load` toggles quotient/root vs remainder (divide/sqrt only),
// `start` clears the block.
//   clk - system clock
//   rst - asynchronous active-low reset
//   io  - output_control_if.slave: core result inputs, raw start/load, display outputs
module output_control
    import output_control_pkg::*;
#(
    parameter int WORD_LENGHT = 8,
    parameter int BCD_DIGITS  = 3
) (
    input  logic             clk,
    input  logic             rst,
    output_control_if.slave  io
);

    out_state_t              state_r;
    out_state_t              state_next_s;

    logic [WORD_LENGHT-1:0]  result_r;
    logic                    result_sign_r;
    logic [WORD_LENGHT-1:0]  remainder_r;
    logic [1:0]              opcode_r;
    logic                    error_r;
    logic                    showing_r;

    logic [WORD_LENGHT:0]    data_r;
    logic                    sign_r;
    logic [4*BCD_DIGITS-1:0] bcd_r;
    logic                    valid_r;
    logic                    busy_r;
    logic                    error_out_r;

    logic                    start_p_s;
    logic                    load_p_s;
    logic                    capture_s;
    logic                    toggle_s;
    logic                    publish_s;
    logic                    conv_start_s;
    logic [WORD_LENGHT-1:0]  conv_bin_s;
    logic                    conv_busy_s;
    logic                    conv_done_s;
    logic [4*BCD_DIGITS-1:0] conv_bcd_s;
    logic                    has_remainder_s;

    // Negative zero is folded to +0 by the caller clearing neg.
    function automatic logic [WORD_LENGHT:0] to_twos(input logic [WORD_LENGHT-1:0] mag,
                                                     input logic neg);
        logic [WORD_LENGHT:0] ext;
        ext = {1'b0, mag};
        if (neg) begin
            return ~ext + {{WORD_LENGHT{1'b0}}, 1'b1};
        end else begin
            return ext;
        end
    endfunction

    ONEshot u_start_os (.clk(clk), .rst(rst), .sig_in(io.start), .pulse_out(start_p_s));
    ONEshot u_load_os  (.clk(clk), .rst(rst), .sig_in(io.load),  .pulse_out(load_p_s));

    bin_to_bcd_seq #(
        .WORD_LENGHT(WORD_LENGHT),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bcd (
        .clk    (clk),
        .rst    (rst),
        .start  (conv_start_s),
        .bin_in (conv_bin_s),
        .busy   (conv_busy_s),
        .done   (conv_done_s),
        .bcd_out(conv_bcd_s)
    );

    assign has_remainder_s = (opcode_r == OP_DIV) || (opcode_r == OP_SQRT);

    // Next-state and control strobes; done > start > load.
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        toggle_s     = 1'b0;
        publish_s    = 1'b0;
        conv_start_s = 1'b0;
        conv_bin_s   = '0;
        if (io.done) begin
            // A new completion is accepted in any state; the converter is
            // started straight from the core inputs so no cycle is lost.
            capture_s    = 1'b1;
            conv_start_s = ~io.error_in;
            conv_bin_s   = io.result;
            state_next_s = io.error_in ? SHOW : CONVERT;
        end else begin
            case (state_r)
                IDLE: begin
                    state_next_s = IDLE;
                end
                CONVERT: begin
                    if (start_p_s) begin
                        state_next_s = IDLE;
                    end else if (conv_done_s && !conv_busy_s) begin
                        publish_s    = 1'b1;
                        state_next_s = SHOW;
                    end else begin
                        state_next_s = CONVERT;
                    end
                end
                SHOW: begin
                    if (start_p_s) begin
                        state_next_s = IDLE;
                    end else if (load_p_s && has_remainder_s && !error_r) begin
                        toggle_s     = 1'b1;
                        conv_start_s = 1'b1;
                        conv_bin_s   = showing_r ? result_r : remainder_r;
                        state_next_s = CONVERT;
                    end else if (!valid_r) begin
                        // Only reachable right after an error capture: the
                        // error display goes out one cycle after capture.
                        publish_s    = 1'b1;
                        state_next_s = SHOW;
                    end else begin
                        state_next_s = SHOW;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Captured core values and the quotient/remainder selection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_r      <= '0;
            result_sign_r <= 1'b0;
            remainder_r   <= '0;
            opcode_r      <= 2'b00;
            error_r       <= 1'b0;
            showing_r     <= 1'b0;
        end else begin
            if (capture_s) begin
                result_r      <= io.result;
                result_sign_r <= io.result_sign;
                remainder_r   <= io.remainder;
                opcode_r      <= io.opCode;
                error_r       <= io.error_in;
            end
            if (capture_s || state_next_s == IDLE) begin
                showing_r <= 1'b0;
            end else if (toggle_s) begin
                showing_r <= ~showing_r;
            end
        end
    end

    // Display registers: cleared in IDLE, loaded when the value is published,
    // otherwise held (valid drops while a new value is being prepared).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r      <= '0;
            sign_r      <= 1'b0;
            bcd_r       <= '0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            error_out_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == CONVERT);
            if (state_next_s == IDLE) begin
                data_r      <= '0;
                sign_r      <= 1'b0;
                bcd_r       <= '0;
                valid_r     <= 1'b0;
                error_out_r <= 1'b0;
            end else if (publish_s) begin
                valid_r <= 1'b1;
                if (error_r) begin
                    data_r      <= '0;
                    sign_r      <= 1'b0;
                    bcd_r       <= {BCD_DIGITS{BCD_ERR_NIBBLE}};
                    error_out_r <= 1'b1;
                end else if (showing_r) begin
                    data_r      <= {1'b0, remainder_r};
                    sign_r      <= 1'b0;
                    bcd_r       <= conv_bcd_s;
                    error_out_r <= 1'b0;
                end else begin
                    data_r      <= to_twos(result_r, result_sign_r && (result_r != '0));
                    sign_r      <= result_sign_r && (result_r != '0);
                    bcd_r       <= conv_bcd_s;
                    error_out_r <= 1'b0;
                end
            end else if (capture_s || state_next_s != SHOW) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign io.data_out          = data_r;
    assign io.sign_out          = sign_r;
    assign io.bcd_out           = bcd_r;
    assign io.valid_out         = valid_r;
    assign io.busy              = busy_r;
    assign io.showing_remainder = showing_r;
    assign io.error_out         = error_out_r;

endmodule

// File: tb/tb_output_control.sv
// tb_output_control
// Directed self-checking bench for output_control with hand-computed expectations.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
module tb_output_control;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    output_control_if #(.WORD_LENGHT(8), .BCD_DIGITS(3)) bus ();

    output_control #(.WORD_LENGHT(8), .BCD_DIGITS(3)) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a result and pulse done for one edge (edge t0); returns just after t0.
    task automatic capture(input logic [7:0] r, input logic s, input logic [7:0] rem,
                           input logic [1:0] op, input logic err);
        bus.result      = r;
        bus.result_sign = s;
        bus.remainder   = rem;
        bus.opCode      = op;
        bus.error_in    = err;
        bus.done        = 1'b1;
        tick(1);
        bus.done        = 1'b0;
        bus.error_in    = 1'b0;
    endtask

    // Raw press: pulse appears after the first edge, action on the second.
    task automatic press_load();
        bus.load = 1'b1;
        tick(1);
        bus.load = 1'b0;
        tick(1);
    endtask

    task automatic press_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(1);
    endtask

    task automatic check_display(input string tag, input logic [8:0] d, input logic s,
                                 input logic [11:0] b);
        check_val({tag, ".valid"}, {31'd0, bus.valid_out}, 32'd1);
        check_val({tag, ".data"},  {23'd0, bus.data_out},  {23'd0, d});
        check_val({tag, ".sign"},  {31'd0, bus.sign_out},  {31'd0, s});
        check_val({tag, ".bcd"},   {20'd0, bus.bcd_out},   {20'd0, b});
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, ".valid"}, {31'd0, bus.valid_out}, 32'd0);
        check_val({tag, ".busy"},  {31'd0, bus.busy},      32'd0);
        check_val({tag, ".data"},  {23'd0, bus.data_out},  32'd0);
        check_val({tag, ".bcd"},   {20'd0, bus.bcd_out},   32'd0);
        check_val({tag, ".err"},   {31'd0, bus.error_out}, 32'd0);
        check_val({tag, ".rem"},   {31'd0, bus.showing_remainder}, 32'd0);
    endtask

    // Directed stimulus sequence.
    initial begin
        total           = 0;
        bad             = 0;
        rst             = 1'b0;
        bus.result      = 8'd0;
        bus.result_sign = 1'b0;
        bus.remainder   = 8'd0;
        bus.opCode      = 2'b00;
        bus.done        = 1'b0;
        bus.error_in    = 1'b0;
        bus.start       = 1'b0;
        bus.load        = 1'b0;

        tick(3);
        check_cleared("reset");
        rst = 1'b1;
        tick(2);
        check_cleared("idle");

        // Multiply -37: valid 9 cycles after the capture edge, load ignored.
        capture(8'd37, 1'b1, 8'd0, 2'b10, 1'b0);
        check_val("mul.busy", {31'd0, bus.busy}, 32'd1);
        tick(8);
        check_val("mul.valid_early", {31'd0, bus.valid_out}, 32'd0);
        tick(1);
        check_display("mul", 9'h1DB, 1'b1, 12'h037);
        press_load();
        tick(3);
        check_display("mul_load", 9'h1DB, 1'b1, 12'h037);
        check_val("mul_load.rem", {31'd0, bus.showing_remainder}, 32'd0);

        press_start();
        check_cleared("start_clear");

        // Divide 100/7 = 14 r 2, toggle to remainder and back.
        capture(8'd14, 1'b0, 8'd2, 2'b00, 1'b0);
        tick(9);
        check_display("div", 9'd14, 1'b0, 12'h014);
        press_load();
        check_val("div_t1.valid_low", {31'd0, bus.valid_out}, 32'd0);
        check_val("div_t1.rem", {31'd0, bus.showing_remainder}, 32'd1);
        check_val("div_t1.data_held", {23'd0, bus.data_out}, 32'd14);
        tick(8);
        check_val("div_t1.valid_still_low", {31'd0, bus.valid_out}, 32'd0);
        tick(1);
        check_display("div_rem", 9'd2, 1'b0, 12'h002);
        check_val("div_rem.rem", {31'd0, bus.showing_remainder}, 32'd1);
        press_load();
        check_val("div_t2.rem", {31'd0, bus.showing_remainder}, 32'd0);
        tick(9);
        check_display("div_back", 9'd14, 1'b0, 12'h014);

        press_start();

        // Error on square root: shown one cycle after capture, load ignored.
        capture(8'd99, 1'b0, 8'd5, 2'b01, 1'b1);
        check_val("err.valid_t0", {31'd0, bus.valid_out}, 32'd0);
        tick(1);
        check_display("err", 9'd0, 1'b0, 12'hFFF);
        check_val("err.flag", {31'd0, bus.error_out}, 32'd1);
        press_load();
        tick(2);
        check_display("err_load", 9'd0, 1'b0, 12'hFFF);
        check_val("err_load.rem", {31'd0, bus.showing_remainder}, 32'd0);
        press_start();
        check_cleared("err_start");

        // Boundary: -255, then recapture from SHOW with negative zero.
        capture(8'd255, 1'b1, 8'd0, 2'b10, 1'b0);
        tick(9);
        check_display("max_neg", 9'h101, 1'b1, 12'h255);
        capture(8'd0, 1'b1, 8'd0, 2'b10, 1'b0);
        check_val("negzero.valid_t0", {31'd0, bus.valid_out}, 32'd0);
        check_val("negzero.data_held", {23'd0, bus.data_out}, 32'h101);
        tick(9);
        check_display("negzero", 9'd0, 1'b0, 12'h000);

        // done and start pulse on the same edge in SHOW: capture wins.
        bus.start       = 1'b1;
        tick(1);
        bus.start       = 1'b0;
        capture(8'd77, 1'b0, 8'd0, 2'b10, 1'b0);
        check_val("coll.busy", {31'd0, bus.busy}, 32'd1);
        tick(9);
        check_display("coll", 9'd77, 1'b0, 12'h077);

        // start mid-CONVERT aborts; the orphaned conversion must not reappear.
        capture(8'd5, 1'b0, 8'd0, 2'b10, 1'b0);
        tick(2);
        press_start();
        check_cleared("abort");
        tick(10);
        check_val("abort.stay_idle", {31'd0, bus.valid_out}, 32'd0);

        // Asynchronous reset mid-CONVERT while the previous value is still held.
        capture(8'd77, 1'b0, 8'd0, 2'b10, 1'b0);
        tick(9);
        capture(8'd200, 1'b0, 8'd0, 2'b10, 1'b0);
        tick(3);
        check_val("rst.busy_before", {31'd0, bus.busy}, 32'd1);
        check_val("rst.data_before", {23'd0, bus.data_out}, 32'd77);
        #2;
        rst = 1'b0;
        #1;
        check_cleared("rst_async");
        tick(2);
        rst = 1'b1;
        tick(2);
        check_cleared("rst_release");

        // Converter recovers after reset.
        capture(8'd123, 1'b0, 8'd0, 2'b10, 1'b0);
        tick(9);
        check_display("after_rst", 9'h07B, 1'b0, 12'h123);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/output_control.md
# output_control

Result-side counterpart of the operand input stage. It captures the sign-magnitude result, remainder and error flag from the arithmetic core when `done` pulses. It converts the displayed value to two's complement, and to BCD with a sequential double-dabble converter. It then holds the value for the display. A debounced `load` press toggles between quotient/root and remainder; a `start` press clears the block for the next operation.

## Interface
- `WORD_LENGHT`, 8, magnitude width of result and remainder
- `BCD_DIGITS`, 3, decimal digits on `bcd_out`; must satisfy 10^BCD_DIGITS > 2^WORD_LENGHT-1
- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `result`  in  WORD_LENGHT  result magnitude from core
- `result_sign`  in  1  result sign, 1 = negative
- `remainder`  in  WORD_LENGHT  remainder/residual magnitude, unsigned
- `opCode`  in  2  registered opcode: 00 divide, 01 square root, 1x multiply
- `done`  in  1  core completion; sampled when high
- `error_in`  in  1  operation error from input stage
- `start`  in  1  raw start level; one-shot internally
- `load`  in  1  raw load level; one-shot internally
- `data_out`  out  WORD_LENGHT+1  two's complement of displayed value
- `sign_out`  out  1  displayed sign
- `bcd_out`  out  4*BCD_DIGITS  packed BCD, digit 0 in LSBs
- `valid_out`  out  1  outputs stable and displayable
- `busy`  out  1  conversion in progress
- `showing_remainder`  out  1  remainder selected
- `error_out`  out  1  captured error

## Operation
- FSM states: IDLE, CONVERT, SHOW.
- IDLE: all outputs 0. When `done` is high, capture `result`, `result_sign`, `remainder`, `opCode` and `error_in`, and clear the selection. If there is no error, go to CONVERT; on error, go to SHOW.
- CONVERT: `busy`=1, `valid_out`=0. The converter runs exactly WORD_LENGHT shift/add-3 iterations on the selected magnitude, then the FSM goes to SHOW.
- SHOW: `valid_out`=1.
  - `load` one-shot with opCode 0x and no error: toggle `showing_remainder`, then go to CONVERT.
  - `load` one-shot with opCode 1x, or with error: ignored.
  - `start` one-shot: go to IDLE.
  - `done`: recapture as in IDLE.
- `start` one-shot during CONVERT aborts to IDLE. `load` during CONVERT is ignored.
- Priority on the same cycle: `done` > `start` > `load`.
- Value rules:
  - Quotient/root: `data_out` = `result_sign` ? -{0,result} : {0,result}.
  - Remainder: `data_out` = {0,remainder}, `sign_out`=0.
  - Negative zero is normalised to `data_out`=0, `sign_out`=0.
  - The width of `data_out` covers the full magnitude range.
- Error: `error_out`=1, `data_out`=0, `sign_out`=0, every BCD nibble 4'hF (display "blank/E").
- Reset (asynchronous, at any time, including mid-CONVERT): state IDLE, all outputs 0, captured registers 0, one-shot history cleared.

## Timing
- `done` sampled at edge t0 → CONVERT from t0 → `valid_out` rises after edge t0+WORD_LENGHT+1 (9 cycles for the default width).
- Error path: `valid_out` rises after t0+1.
- Raw `start`/`load` rising level → one-shot pulse 1 cycle later → action on the following edge.
- Remainder toggle: `valid_out` low for WORD_LENGHT+1 cycles; `bcd_out`/`data_out` update together with the `valid_out` rise.
- `data_out`, `sign_out` and `bcd_out` are registered; they change only on the cycle `valid_out` rises or falls to IDLE.

## Structure
- Package `output_control_pkg`: state enum `out_state_t` (IDLE, CONVERT, SHOW), opcode constants `OP_DIV`=2'b00, `OP_SQRT`=2'b01, `BCD_ERR_NIBBLE`=4'hF.
- Sub-module `bin_to_bcd_seq` (parameters WORD_LENGHT, BCD_DIGITS; ports `clk`, `rst`, `start`, `bin_in`, `busy`, `done`, `bcd_out`): sequential double dabble, one bit per cycle.
- Two instances of the team's `ONEshot` for `start` and `load`.

## Test plan
- Multiply: `result`=37, `result_sign`=1, `opCode`=10, one-cycle `done` → after 9 cycles `valid_out`=1, `data_out`=9'h1DB, `sign_out`=1, `bcd_out`=12'h037; `load` press → no change.
- Divide 100/7: `result`=14, `remainder`=2, `opCode`=00 → `bcd_out`=12'h014. First `load` → `valid_out` low 9 cycles, then `bcd_out`=12'h002, `data_out`=2, `showing_remainder`=1. Second `load` → `bcd_out`=12'h014 again.
- Error: `error_in`=1, `opCode`=01, `done` → `valid_out` after 1 cycle, `error_out`=1, `bcd_out`=12'hFFF, `data_out`=0; `load` ignored; `start` → all outputs 0.
- Boundaries: `result`=255, sign=1 → `data_out`=9'h101, `bcd_out`=12'h255. `result`=0, sign=1 → `data_out`=0, `sign_out`=0, `bcd_out`=0.
- Collisions and reset:
  - `done` and `start` on the same edge in SHOW → new capture wins.
  - `start` mid-CONVERT → IDLE next cycle.
  - `rst` low mid-CONVERT → all outputs 0 immediately, IDLE after release.
